// File: rtl/fetch_unit.sv
// fetch_unit: fetch stage with credit-limited in-order memory requests, a response FIFO to decode,
// and redirect flushes that discard stale in-flight responses.
module fetch_unit #(
    parameter int                 N_param  = 32,
    parameter logic [N_param-1:0] RESET_PC = '0,
    parameter int                 DEPTH    = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    output logic               imem_req_o,
    output logic [N_param-1:0] imem_addr_o,
    input  logic               imem_ready_i,
    input  logic               imem_rsp_valid_i,
    input  logic [N_param-1:0] imem_rsp_data_i,
    input  logic               i_redirect,
    input  logic [N_param-1:0] i_redirect_pc,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [N_param-1:0] instruction_o,
    output logic [N_param-1:0] pc_o,
    output logic               err_o
);
    localparam int                 AW    = $clog2(DEPTH);
    localparam int                 CW    = AW + 1;
    localparam logic [N_param-1:0] NOP   = N_param'(32'h0000_0013);
    localparam logic [N_param-1:0] STEP  = N_param'(4);
    localparam logic [CW:0]        LIMIT = (CW+1)'(DEPTH);

    logic [N_param-1:0] fetch_pc, rsp_pc, target;
    logic [CW-1:0]      count, outstanding, drop, in_flight_after;
    logic [AW-1:0]      rd_ptr, wr_ptr;
    logic               err, accept, has_rsp, unsolicited, push, pop, empty;
    logic [N_param-1:0] pc_mem  [DEPTH];
    logic [N_param-1:0] ins_mem [DEPTH];

    assign empty       = (count == '0);
    assign imem_req_o  = !i_rst && !i_redirect && (({1'b0, count} + {1'b0, outstanding}) < LIMIT);
    assign imem_addr_o = fetch_pc;
    assign accept      = imem_req_o && imem_ready_i;
    assign has_rsp     = imem_rsp_valid_i && (outstanding != '0);
    assign unsolicited = imem_rsp_valid_i && (outstanding == '0);
    // A response arriving in a redirect cycle is stale too, so it never reaches the FIFO.
    assign push        = has_rsp && (drop == '0) && !i_redirect;
    assign valid_o     = !empty && !i_redirect;
    assign pop         = valid_o && ready_i;
    assign instruction_o = empty ? NOP : ins_mem[rd_ptr];
    assign pc_o        = empty ? rsp_pc : pc_mem[rd_ptr];
    assign err_o       = err;
    assign target      = i_redirect_pc & {{(N_param-2){1'b1}}, 2'b00};
    assign in_flight_after = outstanding - CW'(has_rsp);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            err         <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            if (unsolicited) err <= 1'b1;
            if (i_redirect) begin
                count       <= '0;
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                fetch_pc    <= target;
                rsp_pc      <= target;
                outstanding <= in_flight_after;
                drop        <= in_flight_after;
            end else begin
                if (accept) fetch_pc <= fetch_pc + STEP;
                outstanding <= outstanding + CW'(accept) - CW'(has_rsp);
                if (has_rsp && drop != '0) drop <= drop - CW'(1);
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                    rsp_pc <= rsp_pc + STEP;
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            pc_mem[wr_ptr]  <= rsp_pc;
            ins_mem[wr_ptr] <= imem_rsp_data_i;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch_unit bench with a memory model and a queue-based decode scoreboard.
module tb_fetch_unit;
    localparam logic [31:0] RPC = 32'hFFFF_FFF8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_o, imem_ready_i = 1'b0, imem_rsp_valid_i = 1'b0;
    logic [31:0] imem_addr_o, imem_rsp_data_i = '0;
    logic        redirect = 1'b0, valid_o, ready_i = 1'b0, err_o;
    logic [31:0] redirect_pc = '0, instruction_o, pc_o;

    fetch_unit #(.N_param(32), .RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ready_i(imem_ready_i),
        .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_data_i(imem_rsp_data_i),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc),
        .valid_o(valid_o), .ready_i(ready_i), .instruction_o(instruction_o),
        .pc_o(pc_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0;
    int p_imem, p_rsp, p_ready, p_redir, p_unsol, p_rst, lat_min, lat_max;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, a, e);
        end
    endtask

    // Reference model: the expected decode stream is a queue of PCs; in-flight requests carry a stale tag.
    typedef struct { logic [31:0] pc; bit stale; } fl_t;
    fl_t         infl[$];
    logic [31:0] sb[$];
    logic [31:0] m_fetch, rp;
    logic        m_err, e_req, e_valid;
    fl_t         h;

    always @(negedge clk) begin
        if (rst) begin
            chk("req_in_reset", {31'b0, imem_req_o}, 32'd0);
            m_fetch = RPC;
            m_err = 1'b0;
            infl.delete();
            sb.delete();
        end else begin
            e_req   = !redirect && (sb.size() + infl.size() < DEPTH);
            e_valid = (sb.size() != 0) && !redirect;
            rp = m_fetch;
            for (int i = infl.size() - 1; i >= 0; i--) if (!infl[i].stale) rp = infl[i].pc;
            chk("imem_req", {31'b0, imem_req_o}, {31'b0, e_req});
            chk("valid", {31'b0, valid_o}, {31'b0, e_valid});
            chk("err", {31'b0, err_o}, {31'b0, m_err});
            chk("pc", pc_o, sb.size() != 0 ? sb[0] : rp);
            chk("instruction", instruction_o, sb.size() != 0 ? word_at(sb[0]) : 32'h13);
            if (e_req && imem_ready_i) chk("imem_addr", imem_addr_o, m_fetch);
            if (e_valid && ready_i) void'(sb.pop_front());
            if (imem_rsp_valid_i) begin
                if (infl.size() == 0) m_err = 1'b1;
                else begin
                    h = infl.pop_front();
                    if (!h.stale && !redirect) sb.push_back(h.pc);
                end
            end
            if (e_req && imem_ready_i) begin
                infl.push_back('{m_fetch, 1'b0});
                m_fetch += 32'd4;
            end
            if (redirect) begin
                sb.delete();
                foreach (infl[i]) infl[i].stale = 1'b1;
                m_fetch = redirect_pc & ~32'h3;
            end
        end
    end

    typedef struct { logic [31:0] data; int due; } mr_t;
    mr_t memq[$];

    task automatic cycle();
        logic        acc;
        logic [31:0] a;
        @(negedge clk);
        acc = imem_req_o & imem_ready_i;
        a = imem_addr_o;
        @(posedge clk);
        #1;
        cyc++;
        if (acc && !rst) memq.push_back('{word_at(a), cyc + $urandom_range(lat_max, lat_min) - 1});
        rst = ($urandom % 1000) < p_rst;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i = $urandom;
        if (rst) memq.delete();
        else if (memq.size() != 0) begin
            if (memq[0].due <= cyc && ($urandom % 100) < p_rsp) begin
                imem_rsp_valid_i = 1'b1;
                imem_rsp_data_i = memq[0].data;
                void'(memq.pop_front());
            end
        end else if (($urandom % 1000) < p_unsol) imem_rsp_valid_i = 1'b1;
        redirect = ($urandom % 100) < p_redir;
        redirect_pc = $urandom;
        ready_i = ($urandom % 100) < p_ready;
        imem_ready_i = ($urandom % 100) < p_imem;
    endtask

    task automatic phase(input int n, input int imem, input int lmin, input int lmax, input int rsp,
                         input int rdy, input int redir, input int unsol, input int rs);
        p_imem = imem; lat_min = lmin; lat_max = lmax; p_rsp = rsp;
        p_ready = rdy; p_redir = redir; p_unsol = unsol; p_rst = rs;
        repeat (n) cycle();
    endtask

    initial begin
        phase(2,    100, 1, 1, 100, 100,  0,   0, 1000);
        phase(30,   100, 1, 1, 100, 100,  0,   0,    0);
        phase(12,   100, 1, 1, 100,   0,  0,   0,    0);
        phase(20,   100, 1, 1, 100, 100,  0,   0,    0);
        phase(200,  100, 3, 3, 100,  80, 10,   0,    0);
        phase(3000,  70, 1, 5,  70,  60,  5,   0,    0);
        phase(10,     0, 1, 1, 100, 100,  0,   0,    0);
        phase(30,     0, 1, 1, 100,  50,  0, 500,    0);
        phase(1,    100, 1, 1, 100, 100,  0,   0, 1000);
        phase(3000,  80, 1, 4,  80,  70,  4,   5,    5);
        phase(2,    100, 1, 1, 100, 100,  0,   0,    0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
